free_pool_ctrl: RTL and testbench

Controller and arbiter for the physical-register free pool. It sits between the rename stage (allocation requester), the ROB retire path (free requester) and the `free_pool` FIFO, and is the only block that drives the pool's push/pop/data ports. After reset it seeds the pool with every non-architectural tag. During normal operation it arbitrates push versus pop, bypasses a freed tag straight to rename when the pool is empty, and raises a front-end stall when no tag can be supplied.

---
 rtl/free_pool_pkg.sv | 22 ++
 rtl/free_pool_ctrl.sv | 99 +++++++++
 tb/tb_free_pool_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/free_pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | free_pool_pkg                                                        |
// | Shared sizing, control-signal index and FSM encoding for the pool.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package free_pool_pkg;

    localparam int PREG_WIDTH = 6;
    localparam int AREG_COUNT = 32;
    localparam int PREG_COUNT = 64;

    // Bit position of the destination-write flag in the decode control word.
    localparam int REG_WRITE = 3;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/free_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | free_pool_ctrl                                                       |
// | Seeds the physical-register free pool, arbitrates alloc vs free.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module free_pool_ctrl #(
    parameter int PREG_WIDTH = free_pool_pkg::PREG_WIDTH,
    parameter int AREG_COUNT = free_pool_pkg::AREG_COUNT,
    parameter int PREG_COUNT = free_pool_pkg::PREG_COUNT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_gnt,
    output logic [PREG_WIDTH-1:0] alloc_tag,
    input  logic                  free_req,
    input  logic [PREG_WIDTH-1:0] free_tag,
    output logic                  free_ack,
    output logic                  stall,
    output logic                  init_done,
    output logic [PREG_WIDTH-1:0] free_cnt,
    output logic                  pool_push,
    output logic                  pool_pop,
    output logic [PREG_WIDTH-1:0] pool_data_in,
    input  logic [PREG_WIDTH-1:0] pool_data_out,
    input  logic                  pool_empty,
    input  logic                  pool_full
);
    import free_pool_pkg::*;

    localparam logic [PREG_WIDTH-1:0] C_FIRST_SEED = PREG_WIDTH'(AREG_COUNT);
    localparam logic [PREG_WIDTH-1:0] C_LAST_SEED  = PREG_WIDTH'(PREG_COUNT - 1);
    localparam logic [PREG_WIDTH-1:0] C_ONE        = PREG_WIDTH'(1);

    state_t                r_state;
    logic [PREG_WIDTH-1:0] r_init_ptr;
    logic [PREG_WIDTH-1:0] r_free_cnt;
    logic                  r_init_done;

    logic w_run;
    logic w_pop;
    logic w_bypass;
    logic w_push_free;

    assign w_run    = (r_state == ST_RUN);
    assign w_pop    = w_run && alloc_req && !pool_empty;
    // Empty pool with both requesters active: hand the freed tag straight over.
    assign w_bypass = w_run && alloc_req && free_req && pool_empty;
    assign w_push_free = w_run && free_req && (!pool_full || w_pop) && !w_bypass;

    // Seeding push is gated by rst so the pool sees no strobe while held in reset.
    assign pool_push    = rst && (w_run ? w_push_free : 1'b1);
    assign pool_pop     = w_pop;
    assign pool_data_in = w_run ? free_tag : r_init_ptr;

    assign alloc_gnt = w_pop || w_bypass;
    assign alloc_tag = w_bypass ? free_tag : pool_data_out;
    assign free_ack  = w_push_free || w_bypass;
    assign stall     = !w_run || (alloc_req && !alloc_gnt);

    assign init_done = r_init_done;
    assign free_cnt  = r_free_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_INIT;
            r_init_ptr  <= C_FIRST_SEED;
            r_free_cnt  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_ptr <= r_init_ptr + C_ONE;
                    r_free_cnt <= r_free_cnt + C_ONE;
                    if (r_init_ptr == C_LAST_SEED) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_push_free && !w_pop) begin
                        r_free_cnt <= r_free_cnt + C_ONE;
                    end else if (w_pop && !w_push_free) begin
                        r_free_cnt <= r_free_cnt - C_ONE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

    a_free_tag_legal: assert property (
        @(posedge clk) disable iff (!rst)
        (w_run && free_req) |-> (free_tag >= C_FIRST_SEED)
    );

endmodule
`default_nettype wire

// File: tb/tb_free_pool_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_free_pool_ctrl                                                    |
// | Directed self-checking bench with a behavioural pool FIFO.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_free_pool_ctrl;

    localparam int PW = 6;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_gnt;
    logic [PW-1:0] alloc_tag;
    logic          free_req;
    logic [PW-1:0] free_tag;
    logic          free_ack;
    logic          stall;
    logic          init_done;
    logic [PW-1:0] free_cnt;
    logic          pool_push;
    logic          pool_pop;
    logic [PW-1:0] pool_data_in;
    logic [PW-1:0] pool_data_out;
    logic          pool_empty;
    logic          pool_full;

    int n_checks = 0;
    int n_pass   = 0;

    free_pool_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_gnt     (alloc_gnt),
        .alloc_tag     (alloc_tag),
        .free_req      (free_req),
        .free_tag      (free_tag),
        .free_ack      (free_ack),
        .stall         (stall),
        .init_done     (init_done),
        .free_cnt      (free_cnt),
        .pool_push     (pool_push),
        .pool_pop      (pool_pop),
        .pool_data_in  (pool_data_in),
        .pool_data_out (pool_data_out),
        .pool_empty    (pool_empty),
        .pool_full     (pool_full)
    );

    // Behavioural 32-deep pool FIFO, reset by the same rst.
    logic [PW-1:0] r_mem [0:31];
    logic [4:0]    r_rd;
    logic [4:0]    r_wr;
    logic [5:0]    r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (pool_push) begin
                r_mem[r_wr] <= pool_data_in;
                r_wr        <= r_wr + 5'd1;
            end
            if (pool_pop) r_rd <= r_rd + 5'd1;
            r_cnt <= r_cnt + 6'(pool_push) - 6'(pool_pop);
        end
    end

    assign pool_empty    = (r_cnt == 6'd0);
    assign pool_full     = (r_cnt == 6'd32);
    assign pool_data_out = r_mem[r_rd];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_push"}, 32'(pool_push), 32'd0);
        check({tag, "_pop"},  32'(pool_pop),  32'd0);
        check({tag, "_gnt"},  32'(alloc_gnt), 32'd0);
        check({tag, "_ack"},  32'(free_ack),  32'd0);
        check({tag, "_stall"}, 32'(stall),    32'd1);
        check({tag, "_done"}, 32'(init_done), 32'd0);
        check({tag, "_cnt"},  32'(free_cnt),  32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        free_tag  = '0;
        #3;
        check_reset_vals("rst0");

        // First seeding, no requests.
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            check("seed_push", 32'(pool_push), 32'd1);
            check("seed_tag", 32'(pool_data_in), 32'(32 + i));
            check("seed_stall", 32'(stall), 32'd1);
            tick();
            #1;
        end
        check("run_done", 32'(init_done), 32'd1);
        check("run_cnt", 32'(free_cnt), 32'd32);
        check("run_stall", 32'(stall), 32'd0);
        check("run_push", 32'(pool_push), 32'd0);

        // Reset from RUN, then reset again at INIT cycle 10 with alloc_req held.
        rst = 1'b0;
        #1;
        check_reset_vals("rst_run");
        tick();
        rst       = 1'b1;
        alloc_req = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("seed1_tag", 32'(pool_data_in), 32'(32 + i));
            check("seed1_gnt", 32'(alloc_gnt), 32'd0);
            tick();
            #1;
        end
        rst = 1'b0;
        #1;
        check_reset_vals("rst_init");
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            check("seed2_tag", 32'(pool_data_in), 32'(32 + i));
            check("seed2_gnt", 32'(alloc_gnt), 32'd0);
            check("seed2_stall", 32'(stall), 32'd1);
            tick();
            #1;
        end
        check("run2_done", 32'(init_done), 32'd1);

        // Drain all 32 tags in seed order.
        for (int i = 0; i < 32; i++) begin
            check("alloc_gnt", 32'(alloc_gnt), 32'd1);
            check("alloc_pop", 32'(pool_pop), 32'd1);
            check("alloc_tag", 32'(alloc_tag), 32'(32 + i));
            tick();
            #1;
        end
        check("empty_stall", 32'(stall), 32'd1);
        check("empty_gnt", 32'(alloc_gnt), 32'd0);
        check("empty_cnt", 32'(free_cnt), 32'd0);

        // Bypass on an empty pool.
        free_req = 1'b1;
        free_tag = 6'd40;
        #1;
        check("byp_tag", 32'(alloc_tag), 32'd40);
        check("byp_gnt", 32'(alloc_gnt), 32'd1);
        check("byp_ack", 32'(free_ack), 32'd1);
        check("byp_push", 32'(pool_push), 32'd0);
        check("byp_pop", 32'(pool_pop), 32'd0);
        check("byp_stall", 32'(stall), 32'd0);
        tick();
        alloc_req = 1'b0;
        free_req  = 1'b0;
        #1;
        check("byp_cnt", 32'(free_cnt), 32'd0);

        // Refill with frees only.
        for (int i = 0; i < 32; i++) begin
            free_req = 1'b1;
            free_tag = 6'(32 + i);
            #1;
            check("fill_ack", 32'(free_ack), 32'd1);
            check("fill_data", 32'(pool_data_in), 32'(32 + i));
            tick();
        end
        free_req = 1'b0;
        #1;
        check("full_cnt", 32'(free_cnt), 32'd32);

        // Full pool: free alone is refused, free with alloc swaps.
        free_req = 1'b1;
        free_tag = 6'd45;
        #1;
        check("full_noack", 32'(free_ack), 32'd0);
        check("full_nopush", 32'(pool_push), 32'd0);
        alloc_req = 1'b1;
        #1;
        check("swap_pop", 32'(pool_pop), 32'd1);
        check("swap_push", 32'(pool_push), 32'd1);
        check("swap_tag", 32'(alloc_tag), 32'd32);
        check("swap_data", 32'(pool_data_in), 32'd45);
        check("swap_ack", 32'(free_ack), 32'd1);
        check("swap_gnt", 32'(alloc_gnt), 32'd1);
        tick();
        free_req = 1'b0;
        #1;
        check("swap_cnt", 32'(free_cnt), 32'd32);
        check("pop_tag", 32'(alloc_tag), 32'd33);
        tick();
        alloc_req = 1'b0;
        #1;
        check("pop_cnt", 32'(free_cnt), 32'd31);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
